stopwatch_cmd_arbiter: RTL
==========================

# stopwatch_cmd_arbiter

Shares the stopwatch control FSM between two command requesters: the debounced front-panel buttons (requester 0) and the host/debug port (requester 1). Accepts commands over valid/ready handshakes with round-robin arbitration, and checks each command for legality against the FSM's current state. Legal commands are driven as single-cycle start/stop/reset pulses into the FSM. For each command the block confirms the resulting state transition, then returns a status to the requester side.

## Interface
- TIMEOUT, 8: cycles in WAIT without reaching the expected FSM state before declaring timeout (≥1)
- CNT_W, 8: width of error counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a command
- req0_cmd  in  2  requester 0 command: 01 START, 10 STOP, 11 RESET, 00 reserved
- req0_ready  out  1  requester 0 command accepted this cycle (combinational)
- req1_valid / req1_cmd / req1_ready: same as requester 0, for requester 1
- fsm_state  in  2  control FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 invalid
- start  out  1  one-cycle pulse to FSM start input
- stop  out  1  one-cycle pulse to FSM stop input
- reset  out  1  one-cycle pulse to FSM reset input
- cmd_done  out  1  one-cycle response strobe
- cmd_status  out  2  valid with cmd_done: 00 OK, 01 ILLEGAL, 10 TIMEOUT
- cmd_src  out  1  valid with cmd_done: requester that issued the command
- busy  out  1  high in every state except ARB
- err_cnt  out  CNT_W  saturating count of ILLEGAL and TIMEOUT responses

## Operation
- The block is a four-state FSM:
  - ARB: arbitration
  - ISSUE: drive the command pulse
  - WAIT: confirm the state transition
  - RESP: return the response
- ARB behaviour:
  - Grant goes to the single valid requester. If both are valid, grant goes to rr_ptr.
  - readyN = 1 only in ARB and only for the granted requester.
  - A handshake (valid & ready) latches cmd and src, and sets rr_ptr to the non-granted requester.
  - rr_ptr does not change when there is no handshake.
- Legality is evaluated from fsm_state in the handshake cycle:
  - IDLE: START → expect RUNNING.
  - RUNNING: STOP → expect PAUSED; RESET → expect IDLE.
  - PAUSED: START → expect RUNNING; RESET → expect IDLE.
  - Every other combination is ILLEGAL, including cmd 00 and fsm_state 11.
- Legal command: go to ISSUE. Illegal command: go to RESP with status ILLEGAL. No pulse is driven for an illegal command.
- ISSUE: exactly one of start/stop/reset is high for one cycle, then go to WAIT and clear the WAIT counter.
- WAIT:
  - fsm_state == expected: go to RESP with OK.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no match, go to RESP with TIMEOUT.
- RESP: cmd_done = 1 for one cycle with cmd_status and cmd_src, then return to ARB.
- err_cnt increments in each RESP cycle whose status ≠ OK and saturates at all-ones.
- start/stop/reset are registered outputs and are never asserted outside ISSUE. At most one is high at any time.

## Timing
- Reset values:
  - State ARB; rr_ptr = 0.
  - start, stop, reset, cmd_done, busy = 0.
  - cmd_status = 00, cmd_src = 0, err_cnt = 0.
  - req0_ready/req1_ready follow valids combinationally and are live immediately after reset.
- Legal command with handshake in cycle T:
  - Pulse in cycle T+1.
  - FSM state visible in cycle T+2, which is the first WAIT cycle.
  - cmd_done in cycle T+3.
  - Next handshake no earlier than T+4.
- Illegal command with handshake in T: cmd_done (ILLEGAL) in T+1; next handshake no earlier than T+2.
- Timeout: cmd_done at T+2+TIMEOUT.
- Readiness: ready is low from T+1 until the cycle after cmd_done. One command is outstanding at a time.
- Requesters must hold valid and cmd stable until ready.
- Simultaneous valids alternate strictly under continuous contention: 0, 1, 0, 1, ...
- rst_n asserted mid-operation returns the block immediately to ARB:
  - Any in-flight pulse is dropped.
  - No cmd_done is produced for the aborted command.
  - err_cnt clears.

## Test plan
- Reset, fsm_state=IDLE, req0 START → req0_ready in T, start=1 in T+1 only, drive fsm_state=RUNNING from T+2, cmd_done/OK/src=0 in T+3.
- Both valid with START/STOP while PAUSED, after reset → req0 granted first (START, OK). Then req1 STOP is granted, evaluated against RUNNING → OK, expect PAUSED. Then with both held valid, grants alternate 0,1,0.
- fsm_state=IDLE, req1 STOP → no pulse, cmd_done/ILLEGAL/src=1 in T+1, err_cnt=1; repeat with cmd 00 → ILLEGAL, err_cnt=2.
- TIMEOUT=8, RUNNING, req0 STOP with fsm_state held RUNNING → stop pulse at T+1, cmd_done/TIMEOUT at T+10, err_cnt increments.
- Force 2^CNT_W+3 illegal commands → err_cnt saturates at all-ones.
- Assert rst_n low during WAIT → all outputs return to reset values, no cmd_done; the next command is arbitrated with rr_ptr=0.

Source files
------------

// File: rtl/stopwatch_cmd_arbiter.sv
// stopwatch_cmd_arbiter: round-robin command arbiter in front of the stopwatch
// control FSM. Checks each command against the current FSM state, drives a
// one-cycle control pulse for legal commands, confirms the resulting state
// transition and returns a status strobe to the requester side.
module stopwatch_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_cmd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_cmd,
  output logic             req1_ready,
  input  logic [1:0]       fsm_state,
  output logic             start,
  output logic             stop,
  output logic             reset,
  output logic             cmd_done,
  output logic [1:0]       cmd_status,
  output logic             cmd_src,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  localparam logic [1:0] FSM_IDLE    = 2'b00;
  localparam logic [1:0] FSM_RUNNING = 2'b01;
  localparam logic [1:0] FSM_PAUSED  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [1:0]       exp_q, exp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             start_d, stop_d, reset_d, done_d, src_d, busy_d;
  logic [1:0]       status_d;
  logic [CNT_W-1:0] err_d;

  logic             gnt;
  logic             any_valid;
  logic [1:0]       sel_cmd;
  logic             legal;
  logic [1:0]       legal_exp;

  // State and registered-output update; async reset aborts any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_q       <= 1'b0;
      exp_q      <= FSM_IDLE;
      cnt_q      <= '0;
      start      <= 1'b0;
      stop       <= 1'b0;
      reset      <= 1'b0;
      cmd_done   <= 1'b0;
      cmd_status <= ST_OK;
      cmd_src    <= 1'b0;
      busy       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      start      <= start_d;
      stop       <= stop_d;
      reset      <= reset_d;
      cmd_done   <= done_d;
      cmd_status <= status_d;
      cmd_src    <= src_d;
      busy       <= busy_d;
      err_cnt    <= err_d;
    end
  end

  // Arbitration, legality check, next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    reset_d    = 1'b0;
    done_d     = 1'b0;
    status_d   = cmd_status;
    src_d      = cmd_src;
    err_d      = err_cnt;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    legal      = 1'b0;
    legal_exp  = FSM_IDLE;

    any_valid = req0_valid | req1_valid;
    gnt       = (req0_valid && req1_valid) ? rr_q : req1_valid;
    sel_cmd   = gnt ? req1_cmd : req0_cmd;

    case (fsm_state)
      FSM_IDLE: begin
        if (sel_cmd == CMD_START) begin
          legal = 1'b1; legal_exp = FSM_RUNNING;
        end
      end
      FSM_RUNNING: begin
        if (sel_cmd == CMD_STOP) begin
          legal = 1'b1; legal_exp = FSM_PAUSED;
        end else if (sel_cmd == CMD_RESET) begin
          legal = 1'b1; legal_exp = FSM_IDLE;
        end
      end
      FSM_PAUSED: begin
        if (sel_cmd == CMD_START) begin
          legal = 1'b1; legal_exp = FSM_RUNNING;
        end else if (sel_cmd == CMD_RESET) begin
          legal = 1'b1; legal_exp = FSM_IDLE;
        end
      end
      default: ;
    endcase

    case (state_q)
      ARB: begin
        if (any_valid) begin
          req0_ready = ~gnt;
          req1_ready = gnt;
          src_d      = gnt;
          rr_d       = ~gnt;
          if (legal) begin
            state_d = ISSUE;
            exp_d   = legal_exp;
            start_d = (sel_cmd == CMD_START);
            stop_d  = (sel_cmd == CMD_STOP);
            reset_d = (sel_cmd == CMD_RESET);
          end else begin
            state_d  = RESP;
            status_d = ST_ILLEGAL;
            done_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (fsm_state == exp_q) begin
          state_d  = RESP;
          status_d = ST_OK;
          done_d   = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = RESP;
          status_d = ST_TIMEOUT;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = ARB;
        if (cmd_status != ST_OK && err_cnt != {CNT_W{1'b1}}) begin
          err_d = err_cnt + CNT_W'(1);
        end
      end
      default: state_d = ARB;
    endcase

    busy_d = (state_d != ARB);
  end

endmodule
